vector_regfile_v4: RTL and testbench
====================================

Name: vector_regfile_v4

Overview:
Parametrised vector register file for the vector core, the successor to the 8x64-bit, 3-read/1-write register file.
- Element width, register count and port counts are configurable.
- Adds per-element write masks, multiple write ports with fixed priority, and registered reads with same-cycle write forwarding.
- Adds a sequential bulk-clear engine.
- Sits between the decode/issue stage (addresses) and the lane ALUs/load-store unit (data).

Parameters:
VLEN, 64, register width in bits
NUM_REGS, 32, number of vector registers
ELEM_W, 8, element width in bits; VLEN must be a multiple of ELEM_W
NUM_RD, 3, number of read ports
NUM_WR, 2, number of write ports
NELEM, VLEN/ELEM_W, derived: elements per register
AW, $clog2(NUM_REGS), derived: address width

Ports:
clk  in  1  clock
nreset  in  1  asynchronous active-low reset
rd_req  in  [NUM_RD]  read request per port
rd_addr  in  [NUM_RD][AW]  read register address
rd_elem_en  in  [NUM_RD][NELEM]  per-element read enable
rd_data  out  [NUM_RD][VLEN]  registered read data
rd_valid  out  [NUM_RD]  rd_data valid, 1 cycle after rd_req
wr_en  in  [NUM_WR]  write request per port
wr_addr  in  [NUM_WR][AW]  write register address
wr_elem_en  in  [NUM_WR][NELEM]  per-element write mask
wr_data  in  [NUM_WR][VLEN]  write data
clr_req  in  1  start bulk clear of all registers
busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset: one clock, clk; reset nreset is asynchronous, active-low.
- On reset assertion:
  - all registers become 0; rd_data = 0, rd_valid = 0, busy = 0, clr_done = 0; FSM returns to IDLE.
  - Applies immediately, including mid-clear (the clear is aborted; the result is all-zero anyway).
- Register 0 is hardwired zero:
  - writes to address 0 are dropped;
  - reads of address 0 return 0 with rd_valid = 1.
- Write, one cycle:
  - At the posedge, each port with wr_en = 1 and wr_addr != 0 updates only the elements whose wr_elem_en bit is set.
  - Unmasked elements keep their old value.
- Write conflict:
  - Several ports on the same address: masks are merged per element.
  - Where masks overlap, the highest port index wins.
- Read latency is 1 cycle:
  - rd_req at edge t gives rd_valid = 1 and rd_data during cycle t+1.
  - rd_req = 0 gives rd_valid = 0 next cycle; rd_data holds its previous value.
- Forwarding: rd_data reflects writes presented in the same cycle as rd_req, i.e. it samples the post-write value, including merge and priority.
- Disabled read elements (rd_elem_en bit = 0) return 0 in that element slice.
- FSM states IDLE and CLEARING.
  - IDLE -> CLEARING: on clr_req = 1. The counter loads 1; busy = 1 from the next cycle.
  - CLEARING: the register at the counter is zeroed each cycle, then the counter increments.
  - CLEARING -> IDLE: after zeroing NUM_REGS-1, with clr_done = 1 for exactly one cycle; busy = 0 in that same cycle.
  - Total clear duration: NUM_REGS-1 cycles of busy.
- Write and read handling while busy:
  - All write ports are ignored for any cycle in which busy = 1 or clr_req is accepted.
  - Reads while busy = 1 give rd_valid = 0 next cycle.
  - clr_req while CLEARING is ignored.
- Widths: all element slicing is generic over NELEM. No hardcoded byte ranges; each slice is exactly ELEM_W bits, with no overlap.

Decomposition:
- Package vrf_pkg:
  - localparams NELEM and AW;
  - types vreg_t (logic [VLEN-1:0]) and vaddr_t;
  - enum vrf_state_e {IDLE, CLEARING};
  - function elem_mask_expand(mask) -> VLEN-bit mask.
- Sub-module vrf_read_port, instanced NUM_RD times: address decode, element gating, zero-register check, output register and rd_valid.
- Top level: storage, write merge/priority, forwarding next-state and clear FSM.

Test Plan:
- Reset, then read v5 with all elem enables -> rd_valid = 1 at t+1, rd_data = 0; busy = 0.
- Write v3 = 0x1122334455667788 with mask 0xFF, then read v3 with rd_elem_en = 0x0F -> rd_data = 0x0000000055667788.
- Port0 writes v4 = 0xAAAA..AA with mask 0xFF; port1 writes v4 = 0x5555..55 with mask 0x0F, same cycle -> v4 = 0xAAAAAAAA55555555.
- In the same cycle: write v7 = 0xDEADBEEF00000000 (mask 0xF0, old value 0) and read v7 -> next cycle rd_data = 0xDEADBEEF00000000.
- Write to v0 = 0xFFFF..FF, then read v0 -> rd_data = 0, rd_valid = 1.
- Fill v1..v31 with nonzero values, then pulse clr_req:
  - busy high for 31 cycles and clr_done pulses once;
  - a write to v2 issued mid-clear is dropped;
  - afterwards all reads return 0.
- Repeat the clear, but assert nreset at clear cycle 10 -> busy = 0 and clr_done = 0 immediately, and all registers read 0.

Source files
------------

// File: rtl/vector_regfile_v4_pkg.sv
// Shared configuration, types and helpers for the vector register file.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Ports: none. The element/register geometry for the whole block is set here.
package vrf_pkg;

  localparam int VLEN     = 64;   // register width in bits
  localparam int NUM_REGS = 32;   // number of vector registers
  localparam int ELEM_W   = 8;    // element width; VLEN must be a multiple of it
  localparam int NUM_RD   = 3;    // read ports
  localparam int NUM_WR   = 2;    // write ports

  localparam int NELEM = VLEN / ELEM_W;
  localparam int AW    = $clog2(NUM_REGS);

  typedef logic [VLEN-1:0]  vreg_t;
  typedef logic [AW-1:0]    vaddr_t;
  typedef logic [NELEM-1:0] emask_t;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } vrf_state_e;

  // Highest register index; the clear sweep stops after zeroing it.
  localparam vaddr_t LAST_REG = vaddr_t'(NUM_REGS - 1);

  // Widen a per-element mask into a per-bit mask, one ELEM_W slice per bit.
  function automatic vreg_t elem_mask_expand(input emask_t mask);
    vreg_t m;
    m = '0;
    for (int e = 0; e < NELEM; e++) begin
      m[e*ELEM_W +: ELEM_W] = {ELEM_W{mask[e]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/vector_regfile_v4_if.sv
// Bundle of the register-file read, write and clear-control signals.
// Latency: n/a (wiring only).
// Backpressure: none; reads report validity through rd_valid, busy blocks writes.
// master: issue/decode side driving requests; slave: the register file.
interface vector_regfile_v4_if;
  import vrf_pkg::*;

  logic   [NUM_RD-1:0] rd_req;
  vaddr_t [NUM_RD-1:0] rd_addr;
  emask_t [NUM_RD-1:0] rd_elem_en;
  vreg_t  [NUM_RD-1:0] rd_data;
  logic   [NUM_RD-1:0] rd_valid;

  logic   [NUM_WR-1:0] wr_en;
  vaddr_t [NUM_WR-1:0] wr_addr;
  emask_t [NUM_WR-1:0] wr_elem_en;
  vreg_t  [NUM_WR-1:0] wr_data;

  logic clr_req;
  logic busy;
  logic clr_done;

  modport master (
    output rd_req, rd_addr, rd_elem_en, wr_en, wr_addr, wr_elem_en, wr_data, clr_req,
    input  rd_data, rd_valid, busy, clr_done
  );

  modport slave (
    input  rd_req, rd_addr, rd_elem_en, wr_en, wr_addr, wr_elem_en, wr_data, clr_req,
    output rd_data, rd_valid, busy, clr_done
  );

endinterface

// File: rtl/vector_regfile_v4_read_port.sv
// One registered read port: selects a register, gates disabled elements, registers the result.
// Latency: 1 cycle from rd_req_i to rd_valid_o/rd_data_o.
// Backpressure: none; a request while busy_i is dropped (rd_valid_o = 0, data held).
// Ports: regs_i is the post-write register image, rd_*_i request, rd_*_o registered result.
module vrf_read_port
  import vrf_pkg::*;
(
  input  logic                  clk,
  input  logic                  nreset,
  input  vreg_t [NUM_REGS-1:0]  regs_i,
  input  logic                  busy_i,
  input  logic                  rd_req_i,
  input  vaddr_t                rd_addr_i,
  input  emask_t                rd_elem_en_i,
  output vreg_t                 rd_data_o,
  output logic                  rd_valid_o
);

  vreg_t sel_word;
  vreg_t data_q, data_d;
  logic  valid_q, valid_d;

  always_comb begin
    // Register 0 reads as zero regardless of storage contents.
    sel_word = (rd_addr_i == '0) ? '0 : regs_i[rd_addr_i];
    valid_d  = rd_req_i && !busy_i;
    data_d   = valid_d ? (sel_word & elem_mask_expand(rd_elem_en_i)) : data_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;

endmodule

// File: rtl/vector_regfile_v4.sv
// Vector register file: masked multi-port writes, forwarded registered reads, bulk clear engine.
// Latency: writes land at the next edge; reads return 1 cycle after rd_req; clear takes NUM_REGS-1 cycles.
// Backpressure: busy high during clear; writes dropped and reads return rd_valid = 0 meanwhile.
// Ports: clk, nreset (async active-low), bus (slave side of vector_regfile_v4_if).
module vector_regfile_v4
  import vrf_pkg::*;
(
  input  logic                clk,
  input  logic                nreset,
  vector_regfile_v4_if.slave  bus
);

  vreg_t [NUM_REGS-1:0] regs_q, regs_d;
  vrf_state_e           state_q, state_d;
  vaddr_t               cnt_q, cnt_d;
  logic                 clr_done_q, clr_done_d;
  logic                 busy;
  logic                 clr_accept;
  logic                 wr_block;
  vreg_t                wmask;
  vreg_t [NUM_RD-1:0]   rd_data_w;
  logic  [NUM_RD-1:0]   rd_valid_w;

  assign busy       = (state_q == CLEARING);
  assign clr_accept = (state_q == IDLE) && bus.clr_req;
  // The cycle that accepts a clear drops writes too, so nothing lands behind the sweep.
  assign wr_block   = busy || clr_accept;

  always_comb begin : fsm_next
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEARING;
          cnt_d   = vaddr_t'(1);  // register 0 is constant zero, start at 1
        end
      end
      CLEARING: begin
        if (cnt_q == LAST_REG) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + vaddr_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Post-write register image: read ports sample this, which gives same-cycle forwarding.
  // Ports are applied in ascending order so the highest index wins overlapping elements.
  always_comb begin : reg_next
    regs_d = regs_q;
    wmask  = '0;
    if (busy) begin
      regs_d[cnt_q] = '0;
    end else if (!wr_block) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus.wr_en[p] && (bus.wr_addr[p] != '0)) begin
          wmask = elem_mask_expand(bus.wr_elem_en[p]);
          regs_d[bus.wr_addr[p]] = (regs_d[bus.wr_addr[p]] & ~wmask) | (bus.wr_data[p] & wmask);
        end
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      regs_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    vrf_read_port u_rd (
      .clk          (clk),
      .nreset       (nreset),
      .regs_i       (regs_d),
      .busy_i       (busy),
      .rd_req_i     (bus.rd_req[g]),
      .rd_addr_i    (bus.rd_addr[g]),
      .rd_elem_en_i (bus.rd_elem_en[g]),
      .rd_data_o    (rd_data_w[g]),
      .rd_valid_o   (rd_valid_w[g])
    );
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_valid = rd_valid_w;
  assign bus.busy     = busy;
  assign bus.clr_done = clr_done_q;

endmodule

// File: tb/tb_vector_regfile_v4.sv
// Self-checking bench for vector_regfile_v4: directed vector table, clear/reset sequences, random traffic.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_vector_regfile_v4;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  vector_regfile_v4_if bus ();

  vector_regfile_v4 dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: byte-element storage, clear modelled as an instant wipe plus a busy countdown.
  logic [7:0]  mem [32][8];
  int          left;
  logic [63:0] last_d [3];
  logic        exp_v  [3];
  logic        exp_busy;
  logic        exp_done;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [7:0]  wm0, wm1;
    logic [63:0] wd0, wd1;
    logic        rq;
    logic [4:0]  ra;
    logic [7:0]  re;
    logic        ev;
    logic [63:0] ed;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(logic [1:0] wen, logic [4:0] wa0, logic [7:0] wm0, logic [63:0] wd0,
                              logic [4:0] wa1, logic [7:0] wm1, logic [63:0] wd1,
                              logic rq, logic [4:0] ra, logic [7:0] re, logic ev, logic [63:0] ed);
    vec_t v;
    v.wen = wen; v.wa0 = wa0; v.wm0 = wm0; v.wd0 = wd0;
    v.wa1 = wa1; v.wm1 = wm1; v.wd1 = wd1;
    v.rq = rq; v.ra = ra; v.re = re; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_read(int a, logic [7:0] en);
    logic [63:0] r;
    r = '0;
    if (a != 0) begin
      for (int e = 0; e < 8; e++) if (en[e]) r[e*8 +: 8] = mem[a][e];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) for (int e = 0; e < 8; e++) mem[r][e] = 8'h00;
    left = 0;
    for (int p = 0; p < 3; p++) begin last_d[p] = '0; exp_v[p] = 1'b0; end
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  // Predict the effect of the inputs currently on the bus at the coming clock edge.
  task automatic model_step();
    logic was_busy;
    was_busy = (left > 0);
    exp_done = 1'b0;
    if (was_busy) begin
      left--;
      if (left == 0) exp_done = 1'b1;
    end else if (!bus.clr_req) begin
      for (int p = 0; p < 2; p++) begin
        if (bus.wr_en[p] && bus.wr_addr[p] != 0) begin
          for (int e = 0; e < 8; e++)
            if (bus.wr_elem_en[p][e]) mem[bus.wr_addr[p]][e] = bus.wr_data[p][e*8 +: 8];
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      exp_v[p] = bus.rd_req[p] && !was_busy;
      if (exp_v[p]) last_d[p] = model_read(int'(bus.rd_addr[p]), bus.rd_elem_en[p]);
    end
    if (!was_busy && bus.clr_req) begin
      for (int r = 0; r < 32; r++) for (int e = 0; e < 8; e++) mem[r][e] = 8'h00;
      left = 31;
    end
    exp_busy = (left > 0);
  endtask

  task automatic idle_inputs();
    bus.rd_req = '0; bus.rd_addr = '0; bus.rd_elem_en = '0;
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_elem_en = '0; bus.wr_data = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic run_cycle();
    model_step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("rd_valid[%0d]", p), 64'(bus.rd_valid[p]), 64'(exp_v[p]));
      chk($sformatf("rd_data[%0d]", p), bus.rd_data[p], last_d[p]);
    end
    chk("busy", 64'(bus.busy), 64'(exp_busy));
    chk("clr_done", 64'(bus.clr_done), 64'(exp_done));
  endtask

  task automatic fill_all();
    idle_inputs();
    for (int r = 1; r < 32; r++) begin
      bus.wr_en = 2'b01; bus.wr_addr[0] = 5'(r); bus.wr_elem_en[0] = 8'hFF;
      bus.wr_data[0] = {$urandom, $urandom} | 64'h1;
      run_cycle();
    end
    idle_inputs();
  endtask

  task automatic read_all_zero(input string tag);
    idle_inputs();
    for (int r = 1; r < 32; r++) begin
      bus.rd_req = 3'b001; bus.rd_addr[0] = 5'(r); bus.rd_elem_en[0] = 8'hFF;
      run_cycle();
      chk($sformatf("%s v%0d", tag, r), bus.rd_data[0], 64'h0);
    end
    idle_inputs();
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.busy), 64'h0);
    chk("reset clr_done", 64'(bus.clr_done), 64'h0);
    chk("reset rd_valid", 64'(bus.rd_valid), 64'h0);
    chk("reset rd_data0", bus.rd_data[0], 64'h0);
    nreset = 1'b1;

    // Directed single-cycle vectors on read port 0 and both write ports.
    tbl[0]  = mk(2'b00, 5'd0, 8'h00, 64'h0, 5'd0, 8'h00, 64'h0, 1'b1, 5'd5, 8'hFF, 1'b1, 64'h0);
    tbl[1]  = mk(2'b01, 5'd3, 8'hFF, 64'h1122334455667788, 5'd0, 8'h00, 64'h0,
                 1'b0, 5'd0, 8'h00, 1'b0, 64'h0);
    tbl[2]  = mk(2'b00, 5'd0, 8'h00, 64'h0, 5'd0, 8'h00, 64'h0,
                 1'b1, 5'd3, 8'h0F, 1'b1, 64'h0000000055667788);
    tbl[3]  = mk(2'b11, 5'd4, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 5'd4, 8'h0F, 64'h5555555555555555,
                 1'b0, 5'd0, 8'h00, 1'b0, 64'h0000000055667788);
    tbl[4]  = mk(2'b00, 5'd0, 8'h00, 64'h0, 5'd0, 8'h00, 64'h0,
                 1'b1, 5'd4, 8'hFF, 1'b1, 64'hAAAAAAAA55555555);
    tbl[5]  = mk(2'b01, 5'd7, 8'hF0, 64'hDEADBEEF00000000, 5'd0, 8'h00, 64'h0,
                 1'b1, 5'd7, 8'hFF, 1'b1, 64'hDEADBEEF00000000);
    tbl[6]  = mk(2'b11, 5'd0, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 5'd0, 8'hFF, 64'hFFFFFFFFFFFFFFFF,
                 1'b0, 5'd0, 8'h00, 1'b0, 64'hDEADBEEF00000000);
    tbl[7]  = mk(2'b00, 5'd0, 8'h00, 64'h0, 5'd0, 8'h00, 64'h0, 1'b1, 5'd0, 8'hFF, 1'b1, 64'h0);
    tbl[8]  = mk(2'b11, 5'd9, 8'h3C, 64'h0102030405060708, 5'd9, 8'h0F, 64'hF1F2F3F4F5F6F7F8,
                 1'b1, 5'd9, 8'hFF, 1'b1, 64'h00000304F5F6F7F8);
    tbl[9]  = mk(2'b01, 5'd3, 8'h81, 64'hEE000000000000EE, 5'd0, 8'h00, 64'h0,
                 1'b1, 5'd3, 8'hFF, 1'b1, 64'hEE223344556677EE);
    tbl[10] = mk(2'b00, 5'd0, 8'h00, 64'h0, 5'd0, 8'h00, 64'h0,
                 1'b1, 5'd4, 8'hA5, 1'b1, 64'hAA00AA0000550055);

    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      bus.wr_en = tbl[i].wen;
      bus.wr_addr[0] = tbl[i].wa0; bus.wr_elem_en[0] = tbl[i].wm0; bus.wr_data[0] = tbl[i].wd0;
      bus.wr_addr[1] = tbl[i].wa1; bus.wr_elem_en[1] = tbl[i].wm1; bus.wr_data[1] = tbl[i].wd1;
      bus.rd_req[0] = tbl[i].rq; bus.rd_addr[0] = tbl[i].ra; bus.rd_elem_en[0] = tbl[i].re;
      run_cycle();
      chk($sformatf("vec%0d rd_valid", i), 64'(bus.rd_valid[0]), 64'(tbl[i].ev));
      chk($sformatf("vec%0d rd_data", i), bus.rd_data[0], tbl[i].ed);
    end
    idle_inputs();

    // Full clear with a write to v2 issued mid-sweep.
    fill_all();
    bus.clr_req = 1'b1;
    run_cycle();
    bus.clr_req = 1'b0;
    busy_cnt = int'(bus.busy);
    done_cnt = int'(bus.clr_done);
    for (int c = 0; c < 34; c++) begin
      idle_inputs();
      if (c == 5) begin
        bus.wr_en = 2'b11; bus.wr_addr[0] = 5'd2; bus.wr_elem_en[0] = 8'hFF;
        bus.wr_data[0] = 64'hFFFFFFFFFFFFFFFF;
        bus.wr_addr[1] = 5'd2; bus.wr_elem_en[1] = 8'h0F; bus.wr_data[1] = 64'h1234567812345678;
        bus.rd_req = 3'b111; bus.rd_addr = {5'd2, 5'd2, 5'd2}; bus.rd_elem_en = '1;
      end
      if (c == 8) bus.clr_req = 1'b1;  // ignored while clearing
      run_cycle();
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.clr_done);
    end
    chk("clear busy cycles", 64'(busy_cnt), 64'd31);
    chk("clear done pulses", 64'(done_cnt), 64'd1);
    read_all_zero("after clear");

    // Clear interrupted by reset at clear cycle 10.
    fill_all();
    bus.clr_req = 1'b1;
    run_cycle();
    idle_inputs();
    repeat (9) run_cycle();
    chk("pre-reset busy", 64'(bus.busy), 64'h1);
    #3;
    nreset = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'h0);
    chk("abort clr_done", 64'(bus.clr_done), 64'h0);
    chk("abort rd_valid", 64'(bus.rd_valid), 64'h0);
    chk("abort rd_data1", bus.rd_data[1], 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    read_all_zero("after abort");

    // Random traffic over a small address window to provoke conflicts and forwarding.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      bus.wr_en = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        bus.wr_addr[p] = 5'($urandom_range(0, 7));
        bus.wr_elem_en[p] = 8'($urandom);
        bus.wr_data[p] = {$urandom, $urandom};
      end
      bus.rd_req = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) begin
        bus.rd_addr[p] = 5'($urandom_range(0, 7));
        bus.rd_elem_en[p] = 8'($urandom);
      end
      bus.clr_req = ($urandom_range(0, 59) == 0);
      run_cycle();
    end
    idle_inputs();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
